// File: rtl/dct_out_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dct_out_arbiter: round-robin pick of one of two vector banks, streamed  |
// | out element by element with ready backpressure.      Revision: 1.0     |
// +------------------------------------------------------------------------+
module dct_out_arbiter #(
  parameter int M       = 23,
  parameter int E       = 8,
  parameter int arrsize = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   req,
  input  logic [arrsize*(M+E+1)-1:0]   data0,
  input  logic [arrsize*(M+E+1)-1:0]   data1,
  input  logic                         out_ready,
  output logic [1:0]                   grant,
  output logic [1:0]                   ack,
  output logic [M+E:0]                 outp,
  output logic                         out_valid,
  output logic                         out_last,
  output logic                         busy
);

  localparam int              c_W        = M + E + 1;
  localparam int              c_IW       = $clog2(arrsize);
  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(arrsize - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_sel;
  logic                        w_sel_nxt;
  logic                        r_last;
  logic                        w_last_nxt;
  logic [c_IW-1:0]             r_idx;
  logic [c_IW-1:0]             w_idx_nxt;
  logic [arrsize-1:0][c_W-1:0] r_shadow;
  logic [1:0]                  w_grant_oh;

  assign w_grant_oh = {r_sel, ~r_sel};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Shadow copy decouples the stream from later changes on the bank inputs.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_shadow <= r_sel ? data1 : data0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    grant       = 2'b00;
    ack         = 2'b00;
    outp        = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req != 2'b00) begin
          // On a tie the bank that was not served last wins.
          w_sel_nxt   = (req == 2'b11) ? ~r_last : req[1];
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        grant       = w_grant_oh;
        w_idx_nxt   = '0;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        grant     = w_grant_oh;
        out_valid = 1'b1;
        outp      = r_shadow[r_idx];
        out_last  = (r_idx == c_IDX_LAST);
        if (out_ready) begin
          if (r_idx == c_IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + c_IW'(1);
          end
        end
      end
      S_DONE: begin
        grant       = w_grant_oh;
        ack         = w_grant_oh;
        w_last_nxt  = r_sel;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_out_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_dct_out_arbiter: directed scenarios plus randomized transfers.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_dct_out_arbiter;

  localparam int M  = 23;
  localparam int E  = 8;
  localparam int AS = 16;
  localparam int W  = M + E + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [AS*W-1:0] data0;
  logic [AS*W-1:0] data1;
  logic          out_ready;
  logic [1:0]    grant;
  logic [1:0]    ack;
  logic [W-1:0]  outp;
  logic          out_valid;
  logic          out_last;
  logic          busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic last_bank;
  logic p_stall = 1'b0;
  logic [W-1:0] p_outp = '0;

  always #5 clk = ~clk;

  dct_out_arbiter #(.M(M), .E(E), .arrsize(AS)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .out_ready (out_ready),
    .grant     (grant),
    .ack       (ack),
    .outp      (outp),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] oh(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [W-1:0] el(input logic [AS*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  task automatic rand_data();
    for (int k = 0; k < AS; k++) begin
      data0[k*W +: W] = W'($urandom);
      data1[k*W +: W] = W'($urandom);
    end
  endtask

  // Invariants that hold on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_tests++;
      if ((grant & (grant - 2'b01)) != 2'b00 || (ack & (ack - 2'b01)) != 2'b00) begin
        n_fail++;
        $display("FAIL onehot grant=%b ack=%b exp=at most one bit", grant, ack);
      end
      n_tests++;
      if (!out_valid && outp !== '0) begin
        n_fail++;
        $display("FAIL outp_zero got=%h exp=0", outp);
      end
      if (p_stall && out_valid) begin
        n_tests++;
        if (outp !== p_outp) begin
          n_fail++;
          $display("FAIL stall_hold got=%h exp=%h", outp, p_outp);
        end
      end
      p_stall = out_valid && !out_ready;
      p_outp  = outp;
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; out_ready = 1'b1;
    data0 = '0; data1 = '0;
    step();
    step();
    n_tests++;
    if ({grant, ack, outp, out_valid, out_last, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b/%b/%h/%b/%b/%b exp=all zero",
               grant, ack, outp, out_valid, out_last, busy);
    end
    rst_n = 1'b1;
    last_bank = 1'b1;
  endtask

  task automatic test_single();
    for (int k = 0; k < AS; k++) data0[k*W +: W] = W'(32'h3F800000 + k);
    rand_data_bank1();
    req = 2'b01; out_ready = 1'b1;
    step();
    n_tests++;
    if (grant !== 2'b01 || out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant got=%b valid=%b busy=%b exp=01 0 1", grant, out_valid, busy);
    end
    for (int k = 0; k < AS; k++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b1 || outp !== W'(32'h3F800000 + k) || out_last !== (k == AS-1)
          || grant !== 2'b01 || ack !== 2'b00) begin
        n_fail++;
        $display("FAIL single_elem%0d got=%h v=%b l=%b g=%b exp=%h 1 %b 01",
                 k, outp, out_valid, out_last, grant, W'(32'h3F800000 + k), (k == AS-1));
      end
    end
    step();
    req = 2'b00;
    n_tests++;
    if (ack !== 2'b01 || out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack got=%b v=%b busy=%b exp=01 0 1", ack, out_valid, busy);
    end
    step();
    n_tests++;
    if (ack !== 2'b00 || busy !== 1'b0 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle got=ack %b busy %b grant %b exp=00 0 00", ack, busy, grant);
    end
    last_bank = 1'b0;
  endtask

  task automatic rand_data_bank1();
    for (int k = 0; k < AS; k++) data1[k*W +: W] = W'($urandom);
  endtask

  task automatic test_fairness();
    int         ac[3];
    logic [1:0] ab[3];
    int         na = 0;
    rst_n = 1'b0; req = 2'b00;
    step();
    rst_n = 1'b1; last_bank = 1'b1;
    rand_data();
    req = 2'b11; out_ready = 1'b1;
    for (int c = 1; c <= 70 && na < 3; c++) begin
      step();
      if (ack != 2'b00) begin
        ac[na] = c; ab[na] = ack; na++;
        if (na == 3) req = 2'b00;
      end
    end
    n_tests++;
    if (na !== 3) begin
      n_fail++;
      $display("FAIL fair_ack_count got=%0d exp=3", na);
    end else begin
      n_tests++;
      if (ab[0] !== 2'b01 || ab[1] !== 2'b10 || ab[2] !== 2'b01) begin
        n_fail++;
        $display("FAIL fair_order got=%b %b %b exp=01 10 01", ab[0], ab[1], ab[2]);
      end
      n_tests++;
      if (ac[0] != AS + 2 || ac[1] - ac[0] != AS + 3 || ac[2] - ac[1] != AS + 3) begin
        n_fail++;
        $display("FAIL fair_timing got=%0d %0d %0d exp=%0d +%0d +%0d",
                 ac[0], ac[1]-ac[0], ac[2]-ac[1], AS+2, AS+3, AS+3);
      end
    end
    step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_idle got=%b exp=0", busy);
    end
    last_bank = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got[$];
    int hold = 0, ack_c = -1, na = 0;
    rand_data();
    req = 2'b01; out_ready = 1'b1;
    for (int c = 1; c <= AS + 6; c++) begin
      step();
      out_ready = !(c >= 7 && c <= 9);
      if (out_valid && outp == el(data0, 5)) hold++;
      if (out_valid && out_ready) got.push_back(outp);
      if (ack != 2'b00) begin
        n_tests++;
        if (ack !== 2'b01) begin
          n_fail++;
          $display("FAIL bp_ack_bank got=%b exp=01", ack);
        end
        ack_c = c; na++; req = 2'b00;
      end
    end
    n_tests++;
    if (hold != 4) begin
      n_fail++;
      $display("FAIL bp_hold got=%0d exp=4", hold);
    end
    n_tests++;
    if (ack_c != AS + 5 || na != 1) begin
      n_fail++;
      $display("FAIL bp_ack_time got=%0d count=%0d exp=%0d count=1", ack_c, na, AS + 5);
    end
    n_tests++;
    if (got.size() != AS) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=%0d", got.size(), AS);
    end else begin
      for (int k = 0; k < AS; k++) begin
        n_tests++;
        if (got[k] !== el(data0, k)) begin
          n_fail++;
          $display("FAIL bp_elem%0d got=%h exp=%h", k, got[k], el(data0, k));
        end
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle got=%b exp=0", busy);
    end
    last_bank = 1'b0;
  endtask

  task automatic test_isolation();
    logic [AS*W-1:0] snap;
    rand_data();
    snap = data0;
    req = 2'b01; out_ready = 1'b1;
    step();
    n_tests++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL iso_grant got=%b exp=01", grant);
    end
    for (int k = 0; k < AS; k++) begin
      step();
      if (k == 0) data0 = '1;
      n_tests++;
      if (outp !== el(snap, k) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL iso_elem%0d got=%h v=%b exp=%h 1", k, outp, out_valid, el(snap, k));
      end
    end
    step();
    req = 2'b00;
    n_tests++;
    if (ack !== 2'b01) begin
      n_fail++;
      $display("FAIL iso_ack got=%b exp=01", ack);
    end
    step();
    last_bank = 1'b0;
  endtask

  task automatic test_reset_midstream();
    rand_data();
    req = 2'b01; out_ready = 1'b1;
    step();
    for (int k = 0; k <= 7; k++) step();
    n_tests++;
    if (outp !== el(data0, 7)) begin
      n_fail++;
      $display("FAIL rst_mid_pre got=%h exp=%h", outp, el(data0, 7));
    end
    rst_n = 1'b0; req = 2'b00;
    step();
    n_tests++;
    if ({grant, ack, outp, out_valid, out_last, busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_zero got=%b/%b/%h/%b/%b/%b exp=all zero",
               grant, ack, outp, out_valid, out_last, busy);
    end
    rst_n = 1'b1; last_bank = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (ack !== 2'b00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_noack got=ack %b busy %b exp=00 0", ack, busy);
      end
    end
    req = 2'b10;
    step();
    n_tests++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_grant got=%b exp=10", grant);
    end
    for (int k = 0; k < AS; k++) begin
      step();
      n_tests++;
      if (outp !== el(data1, k) || out_last !== (k == AS-1)) begin
        n_fail++;
        $display("FAIL rst_mid_elem%0d got=%h l=%b exp=%h %b", k, outp, out_last, el(data1, k), (k == AS-1));
      end
    end
    step();
    req = 2'b00;
    n_tests++;
    if (ack !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_ack got=%b exp=10", ack);
    end
    step();
    last_bank = 1'b1;
  endtask

  task automatic test_withdraw();
    int na = 0;
    rand_data();
    req = 2'b01; out_ready = 1'b1;
    step();
    for (int k = 0; k < AS; k++) begin
      step();
      if (k == 3) req = 2'b00;
      n_tests++;
      if (outp !== el(data0, k) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL wd_elem%0d got=%h v=%b exp=%h 1", k, outp, out_valid, el(data0, k));
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (ack == 2'b01) na++;
    end
    n_tests++;
    if (na != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_ack got=%0d busy=%b exp=1 0", na, busy);
    end
    last_bank = 1'b0;
  endtask

  // Transaction-level model: bank choice from the round-robin rule, payload
  // from the LOAD-cycle snapshot, ack one cycle after the arrsize-th handshake.
  task automatic test_random();
    logic [AS*W-1:0] snap;
    logic [1:0]      r;
    logic            eb;
    int              n, guard;
    for (int t = 0; t < 40; t++) begin
      for (int i = $urandom_range(0, 2); i > 0; i--) begin
        req = 2'b00;
        step();
        n_tests++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
          n_fail++;
          $display("FAIL rnd_idle t%0d busy=%b grant=%b exp=0 00", t, busy, grant);
        end
      end
      r = 2'($urandom_range(1, 3));
      eb = (r == 2'b11) ? ~last_bank : r[1];
      req = r;
      rand_data();
      out_ready = 1'b1;
      step();
      snap = eb ? data1 : data0;
      n_tests++;
      if (grant !== oh(eb) || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_grant t%0d got=%b v=%b exp=%b 0", t, grant, out_valid, oh(eb));
      end
      n = 0; guard = 0;
      while (n < AS && guard < 200) begin
        step();
        guard++;
        req = 2'($urandom);
        rand_data();
        out_ready = ($urandom_range(0, 3) != 0);
        n_tests++;
        if (out_valid !== 1'b1 || outp !== el(snap, n) || out_last !== (n == AS-1)
            || grant !== oh(eb)) begin
          n_fail++;
          $display("FAIL rnd_elem t%0d k%0d got=%h v=%b l=%b g=%b exp=%h 1 %b %b",
                   t, n, outp, out_valid, out_last, grant, el(snap, n), (n == AS-1), oh(eb));
        end
        if (out_ready) n++;
      end
      if (n < AS) begin
        n_tests++; n_fail++;
        $display("FAIL rnd_timeout t%0d got=%0d exp=%0d", t, n, AS);
        break;
      end
      step();
      n_tests++;
      if (ack !== oh(eb) || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_ack t%0d got=%b v=%b exp=%b 0", t, ack, out_valid, oh(eb));
      end
      req = 2'b00;
      step();
      n_tests++;
      if (busy !== 1'b0 || ack !== 2'b00) begin
        n_fail++;
        $display("FAIL rnd_end t%0d busy=%b ack=%b exp=0 00", t, busy, ack);
      end
      last_bank = eb;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; out_ready = 1'b1;
    data0 = '0; data1 = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_isolation();
    test_reset_midstream();
    test_withdraw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
